soc_uart_bridge_rw: RTL and testbench

//  Byte-stream command bridge giving a host read/write access to SoC memory over UART.

---
 rtl/soc_uart_bridge_rw_if.sv | 33 +++
 rtl/soc_uart_bridge_rw.sv | 246 ++++++++++++++++++++++++
 tb/tb_soc_uart_bridge_rw.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_uart_bridge_rw_if.sv
// Bus bundle between the UART byte core, the bridge and the memory-bus slave.
// The master modport is the bridge's view; slave is the environment's view.
interface soc_uart_bridge_rw_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  rx_error;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  mem_req;
  logic                  mem_write_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_write_data;
  logic [DATA_W/8-1:0]   mem_byte_en;
  logic [DATA_W-1:0]     mem_read_data;
  logic                  mem_valid;

  modport master (
    input  rx_valid, rx_data, rx_error, tx_ready, mem_read_data, mem_valid,
    output rx_ready, tx_valid, tx_data, mem_req, mem_write_en, mem_addr,
           mem_write_data, mem_byte_en
  );

  modport slave (
    output rx_valid, rx_data, rx_error, tx_ready, mem_read_data, mem_valid,
    input  rx_ready, tx_valid, tx_data, mem_req, mem_write_en, mem_addr,
           mem_write_data, mem_byte_en
  );
endinterface

// File: rtl/soc_uart_bridge_rw.sv
// UART command bridge: parses opcode/address/count byte streams and performs
// memory write/read bursts with CRC-32 over the payload and rx/mem timeouts.
module soc_uart_bridge_rw #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int CNT_BYTES   = 2,
  parameter int RX_TIMEOUT  = 1000000,
  parameter int MEM_TIMEOUT = 256,
  parameter int READ_EN     = 1
) (
  input logic                 clk,
  input logic                 res_n,
  soc_uart_bridge_rw_if.master bus
);
  localparam int WB    = DATA_W / 8;
  localparam int AB    = ADDR_W / 8;
  localparam int CW    = 8 * CNT_BYTES;
  localparam int ALIGN = $clog2(WB);

  localparam logic [31:0]       CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0]       CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << ALIGN) - 1);
  localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52;
  localparam logic [7:0] ST_OK = 8'h59, ST_CRC = 8'h23, ST_UNK = 8'h3F;
  localparam logic [7:0] ST_TMO = 8'h54, ST_ERR = 8'hE0;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_W_DATA, S_W_MEM, S_W_CRC,
    S_R_MEM, S_R_SEND, S_R_CRC, S_RESP, S_ERROR
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        idx, idx_nx;
  logic [ADDR_W-1:0] addr, addr_nx, addr_sh;
  logic [DATA_W-1:0] wbuf, wbuf_nx, wbuf_sh, rbuf, rbuf_nx;
  logic [CW-1:0]     cnt, cnt_nx, cnt_sh;
  logic [31:0]       crc, crc_nx, crc_fin, crc_rx, crc_rx_nx, crc_rx_sh;
  logic [31:0]       rx_tcnt, rx_tcnt_nx, mem_tcnt, mem_tcnt_nx;
  logic [7:0]        status, status_nx, tx_byte;
  logic              is_wr, is_wr_nx;
  logic              rx_state, rx_cnt_state, mem_state;
  logic              rx_acc, tx_acc, tx_vld, rx_tmo, mem_tmo;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  assign rx_state     = state inside {S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_W_DATA, S_W_CRC};
  assign rx_cnt_state = rx_state && (state != S_IDLE);
  assign mem_state    = state inside {S_W_MEM, S_R_MEM};
  assign rx_acc       = bus.rx_valid && bus.rx_ready;
  assign tx_acc       = tx_vld && bus.tx_ready;
  assign rx_tmo       = (RX_TIMEOUT != 0) && rx_cnt_state && !rx_acc &&
                        (rx_tcnt == 32'(RX_TIMEOUT - 1));
  assign mem_tmo      = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_valid &&
                        (mem_tcnt == 32'(MEM_TIMEOUT - 1));

  // Little-endian fields: each new byte enters at the top and the field shifts down.
  assign addr_sh   = (addr >> 8) | (ADDR_W'(bus.rx_data) << (ADDR_W - 8));
  assign cnt_sh    = (cnt >> 8) | (CW'(bus.rx_data) << (CW - 8));
  assign wbuf_sh   = (wbuf >> 8) | (DATA_W'(bus.rx_data) << (DATA_W - 8));
  assign crc_rx_sh = {bus.rx_data, crc_rx[31:8]};
  assign crc_fin   = ~crc;

  assign bus.rx_ready       = rx_state && !bus.rx_error;
  assign bus.tx_valid       = tx_vld;
  assign bus.tx_data        = tx_vld ? tx_byte : 8'h00;
  assign bus.mem_req        = mem_state;
  assign bus.mem_write_en   = (state == S_W_MEM);
  assign bus.mem_addr       = addr;
  assign bus.mem_write_data = wbuf;
  assign bus.mem_byte_en    = '1;

  always_comb begin
    tx_vld  = 1'b0;
    tx_byte = 8'h00;
    case (state)
      S_RESP:   begin tx_vld = 1'b1; tx_byte = status; end
      S_R_SEND: begin tx_vld = 1'b1; tx_byte = rbuf[7:0]; end
      S_R_CRC:  begin tx_vld = 1'b1; tx_byte = crc_fin[{idx[1:0], 3'b000} +: 8]; end
      S_ERROR:  begin tx_vld = (idx == 4'd0); tx_byte = ST_ERR; end
      default:  ;
    endcase
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    addr_nx     = addr;
    wbuf_nx     = wbuf;
    rbuf_nx     = rbuf;
    cnt_nx      = cnt;
    crc_nx      = crc;
    crc_rx_nx   = crc_rx;
    status_nx   = status;
    is_wr_nx    = is_wr;
    rx_tcnt_nx  = (rx_acc || state == S_IDLE) ? 32'd0 :
                  (rx_cnt_state ? rx_tcnt + 32'd1 : rx_tcnt);
    mem_tcnt_nx = mem_state ? mem_tcnt + 32'd1 : 32'd0;

    case (state)
      S_IDLE: if (rx_acc) begin
        idx_nx = 4'd0;
        crc_nx = CRC_INIT;
        if (bus.rx_data == OP_WR) begin
          is_wr_nx = 1'b1;
          state_nx = S_HDR_ADDR;
        end else if (bus.rx_data == OP_RD && READ_EN != 0) begin
          is_wr_nx = 1'b0;
          state_nx = S_HDR_ADDR;
        end else begin
          status_nx = ST_UNK;
          state_nx  = S_RESP;
        end
      end
      S_HDR_ADDR: if (rx_acc) begin
        if (idx == 4'(AB - 1)) begin
          addr_nx  = addr_sh & ADDR_MASK;
          idx_nx   = 4'd0;
          state_nx = S_HDR_CNT;
        end else begin
          addr_nx = addr_sh;
          idx_nx  = idx + 4'd1;
        end
      end
      S_HDR_CNT: if (rx_acc) begin
        cnt_nx = cnt_sh;
        if (idx == 4'(CNT_BYTES - 1)) begin
          idx_nx = 4'd0;
          if (cnt_sh == '0) state_nx = is_wr ? S_W_CRC : S_R_CRC;
          else              state_nx = is_wr ? S_W_DATA : S_R_MEM;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      S_W_DATA: if (rx_acc) begin
        wbuf_nx = wbuf_sh;
        crc_nx  = crc_step(crc, bus.rx_data);
        if (idx == 4'(WB - 1)) begin
          idx_nx   = 4'd0;
          state_nx = S_W_MEM;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      S_W_MEM: if (bus.mem_valid) begin
        addr_nx  = addr + ADDR_W'(WB);
        cnt_nx   = cnt - CW'(1);
        state_nx = (cnt == CW'(1)) ? S_W_CRC : S_W_DATA;
      end else if (mem_tmo) begin
        status_nx = ST_TMO;
        state_nx  = S_RESP;
      end
      S_W_CRC: if (rx_acc) begin
        crc_rx_nx = crc_rx_sh;
        if (idx == 4'd3) begin
          status_nx = (crc_rx_sh == crc_fin) ? ST_OK : ST_CRC;
          state_nx  = S_RESP;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      S_R_MEM: if (bus.mem_valid) begin
        rbuf_nx  = bus.mem_read_data;
        idx_nx   = 4'd0;
        state_nx = S_R_SEND;
      end else if (mem_tmo) begin
        status_nx = ST_TMO;
        state_nx  = S_RESP;
      end
      S_R_SEND: if (tx_acc) begin
        rbuf_nx = rbuf >> 8;
        crc_nx  = crc_step(crc, rbuf[7:0]);
        if (idx == 4'(WB - 1)) begin
          idx_nx   = 4'd0;
          addr_nx  = addr + ADDR_W'(WB);
          cnt_nx   = cnt - CW'(1);
          state_nx = (cnt == CW'(1)) ? S_R_CRC : S_R_MEM;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      S_R_CRC: if (tx_acc) begin
        if (idx == 4'd3) begin
          idx_nx   = 4'd0;
          state_nx = S_IDLE;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      S_RESP: if (tx_acc) state_nx = S_IDLE;
      S_ERROR: begin
        // idx flags that the error byte has already gone out
        if (idx == 4'd0) begin
          if (tx_acc) idx_nx = 4'd1;
        end else if (!bus.rx_error) begin
          idx_nx   = 4'd0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (rx_tmo) begin
      status_nx = ST_TMO;
      idx_nx    = 4'd0;
      state_nx  = S_RESP;
    end
    if (bus.rx_error && state != S_ERROR) begin
      idx_nx   = 4'd0;
      state_nx = S_ERROR;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= S_IDLE;
      idx      <= 4'd0;
      addr     <= '0;
      wbuf     <= '0;
      crc      <= CRC_INIT;
      is_wr    <= 1'b0;
      rx_tcnt  <= 32'd0;
      mem_tcnt <= 32'd0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      addr     <= addr_nx;
      wbuf     <= wbuf_nx;
      crc      <= crc_nx;
      is_wr    <= is_wr_nx;
      rx_tcnt  <= rx_tcnt_nx;
      mem_tcnt <= mem_tcnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    cnt    <= cnt_nx;
    rbuf   <= rbuf_nx;
    crc_rx <= crc_rx_nx;
    status <= status_nx;
  end
endmodule

// File: tb/tb_soc_uart_bridge_rw.sv
// Bench for soc_uart_bridge_rw: table-driven and random commands against a
// byte-level model of the command protocol, plus timeout/error/reset sequences.
module tb_soc_uart_bridge_rw;
  localparam int RX_TMO  = 40;
  localparam int MEM_TMO = 16;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  soc_uart_bridge_rw_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  soc_uart_bridge_rw #(
    .DATA_W(32), .ADDR_W(32), .CNT_BYTES(2),
    .RX_TIMEOUT(RX_TMO), .MEM_TIMEOUT(MEM_TMO), .READ_EN(1)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          flip;
    int          status;
  } vec_t;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   tx_q[$];
  logic [63:0]  wr_q[$];
  logic [31:0]  mem[logic [31:0]];
  bit           withhold = 1'b0;
  int           lat = 0;
  vec_t         tbl[11];
  logic [31:0]  wq[$];
  logic [7:0]   sq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Memory slave: random latency, one-cycle mem_valid, write log.
  always @(posedge clk) begin
    if (!res_n) begin
      bus.mem_valid <= 1'b0;
      lat <= 0;
    end else begin
      bus.mem_valid <= 1'b0;
      if (bus.mem_req && !bus.mem_valid && !withhold) begin
        if (lat == 0) begin
          bus.mem_valid <= 1'b1;
          if (bus.mem_write_en) begin
            mem[bus.mem_addr] = bus.mem_write_data;
            wr_q.push_back({bus.mem_addr, bus.mem_write_data});
          end else begin
            bus.mem_read_data <= mem_val(bus.mem_addr);
          end
          lat <= $urandom_range(0, 3);
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (res_n && bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
    bus.tx_ready <= ($urandom_range(0, 3) != 0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("rx_accept_timeout", 64'(n), 64'(0));
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int need);
    int k = 0;
    while (tx_q.size() < need && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) check("tx_wait_timeout", 64'(tx_q.size()), 64'(need));
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input int cnt,
                         input logic [31:0] words[$], input bit flip, input int status);
    logic [7:0]  rxb[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  pay[$];
    logic [63:0] exp_wr[$];
    logic [31:0] base, crc, w;
    logic [15:0] c16;
    base = addr & ~32'h3;
    c16  = 16'(cnt);
    rxb.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int i = 0; i < 4; i++) rxb.push_back(addr[8*i +: 8]);
      rxb.push_back(c16[7:0]);
      rxb.push_back(c16[15:8]);
    end
    if (op == 8'h57) begin
      for (int i = 0; i < cnt; i++) begin
        w = words[i];
        for (int j = 0; j < 4; j++) begin
          rxb.push_back(w[8*j +: 8]);
          pay.push_back(w[8*j +: 8]);
        end
        exp_wr.push_back({base + 32'(4 * i), w});
      end
      crc = ref_crc(pay);
      if (flip) crc = crc ^ 32'h0000_0100;
      for (int j = 0; j < 4; j++) rxb.push_back(crc[8*j +: 8]);
      exp_tx.push_back(status[7:0]);
    end else if (op == 8'h52) begin
      for (int i = 0; i < cnt; i++) begin
        w = mem_val(base + 32'(4 * i));
        for (int j = 0; j < 4; j++) begin
          exp_tx.push_back(w[8*j +: 8]);
          pay.push_back(w[8*j +: 8]);
        end
      end
      crc = ref_crc(pay);
      for (int j = 0; j < 4; j++) exp_tx.push_back(crc[8*j +: 8]);
    end else begin
      exp_tx.push_back(status[7:0]);
    end
    tx_q.delete();
    wr_q.delete();
    foreach (rxb[i]) send_byte(rxb[i], $urandom_range(0, 3));
    wait_tx(exp_tx.size());
    repeat (6) @(negedge clk);
    check("tx_len", 64'(tx_q.size()), 64'(exp_tx.size()));
    foreach (exp_tx[i]) if (i < tx_q.size()) check("tx_byte", 64'(tx_q[i]), 64'(exp_tx[i]));
    check("wr_len", 64'(wr_q.size()), 64'(exp_wr.size()));
    foreach (exp_wr[i]) if (i < wr_q.size()) check("wr_addr_data", wr_q[i], exp_wr[i]);
    check("back_to_idle", 64'(bus.rx_ready), 64'(1));
  endtask

  initial begin
    logic [7:0]  op, b;
    logic [31:0] a;
    int          n, r, cnt;
    bit          flip;

    tbl[0]  = '{8'h57, 32'h0000_1000, 2, 32'h1122_3344, 32'h5566_7788, 1'b0, 'h59};
    tbl[1]  = '{8'h57, 32'h0000_1000, 2, 32'h1122_3344, 32'h5566_7788, 1'b1, 'h23};
    tbl[2]  = '{8'h57, 32'h0000_1000, 1, 32'hDEAD_BEEF, 32'h0,         1'b0, 'h59};
    tbl[3]  = '{8'h52, 32'h0000_1002, 1, 32'h0,         32'h0,         1'b0, -1};
    tbl[4]  = '{8'h41, 32'h0,         0, 32'h0,         32'h0,         1'b0, 'h3F};
    tbl[5]  = '{8'h57, 32'hFFFF_FFFC, 2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 'h59};
    tbl[6]  = '{8'h57, 32'h0000_2000, 0, 32'h0,         32'h0,         1'b0, 'h59};
    tbl[7]  = '{8'h57, 32'h0000_2000, 0, 32'h0,         32'h0,         1'b1, 'h23};
    tbl[8]  = '{8'h52, 32'h0000_2000, 0, 32'h0,         32'h0,         1'b0, -1};
    tbl[9]  = '{8'h52, 32'hFFFF_FFFE, 2, 32'h0,         32'h0,         1'b0, -1};
    tbl[10] = '{8'h52, 32'h0000_1000, 2, 32'h0,         32'h0,         1'b0, -1};

    res_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
    check("rst_tx_data", 64'(bus.tx_data), 64'(0));
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_write_en", 64'(bus.mem_write_en), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_mem_write_data", 64'(bus.mem_write_data), 64'(0));
    check("byte_en", 64'(bus.mem_byte_en), 64'hF);
    res_n = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 64'(bus.rx_ready), 64'(1));

    sq.delete();
    for (int i = 0; i < 9; i++) sq.push_back(8'(8'h31 + i));
    check("crc_model_check", 64'(ref_crc(sq)), 64'hCBF4_3926);

    for (int i = 0; i < 11; i++) begin
      wq.delete();
      wq.push_back(tbl[i].w0);
      wq.push_back(tbl[i].w1);
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].cnt, wq, tbl[i].flip, tbl[i].status);
    end

    // Header stalls past the rx timeout.
    tx_q.delete();
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    repeat (RX_TMO - 2) @(negedge clk);
    check("rx_tmo_not_early", 64'(bus.tx_valid), 64'(0));
    wait_tx(1);
    repeat (4) @(negedge clk);
    check("rx_tmo_len", 64'(tx_q.size()), 64'(1));
    if (tx_q.size() > 0) check("rx_tmo_status", 64'(tx_q[0]), 64'h54);
    wq.delete();
    wq.push_back(32'hCAFE_F00D);
    run_cmd(8'h57, 32'h0000_3000, 1, wq, 1'b0, 'h59);

    // Memory never answers a read.
    tx_q.delete();
    withhold = 1'b1;
    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    n = 0;
    while (!bus.mem_req && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (bus.mem_req && n < 100) begin n++; @(negedge clk); end
    check("mem_tmo_req_cycles", 64'(n), 64'(MEM_TMO));
    wait_tx(1);
    repeat (4) @(negedge clk);
    check("mem_tmo_len", 64'(tx_q.size()), 64'(1));
    if (tx_q.size() > 0) check("mem_tmo_status", 64'(tx_q[0]), 64'h54);
    withhold = 1'b0;

    // rx_error in the middle of write data.
    tx_q.delete();
    wr_q.delete();
    send_byte(8'h57, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h40, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    bus.rx_error = 1'b1;
    wait_tx(1);
    repeat (10) @(negedge clk);
    check("err_len", 64'(tx_q.size()), 64'(1));
    if (tx_q.size() > 0) check("err_byte", 64'(tx_q[0]), 64'hE0);
    check("err_hold_rx_ready", 64'(bus.rx_ready), 64'(0));
    bus.rx_error = 1'b0;
    repeat (2) @(negedge clk);
    check("err_cleared_idle", 64'(bus.rx_ready), 64'(1));
    check("err_no_write", 64'(wr_q.size()), 64'(0));

    // Asynchronous reset while a write request is outstanding.
    withhold = 1'b1;
    send_byte(8'h57, 0);
    send_byte(8'h08, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h99, 0);
    n = 0;
    while (!bus.mem_req && n < 50) begin @(negedge clk); n++; end
    check("wmem_reached", 64'(bus.mem_req), 64'(1));
    res_n = 1'b0;
    #1;
    check("arst_outputs",
          {29'h0, bus.mem_req, bus.mem_write_en, bus.tx_valid, bus.tx_data, bus.mem_write_data[23:0]},
          64'h0);
    check("arst_addr", 64'(bus.mem_addr), 64'h0);
    @(negedge clk);
    res_n = 1'b1;
    withhold = 1'b0;
    @(negedge clk);
    wq.delete();
    wq.push_back(32'h0BAD_F00D);
    wq.push_back(32'h1234_5678);
    run_cmd(8'h57, 32'h0000_4004, 2, wq, 1'b0, 'h59);

    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      if (r < 5) op = 8'h57;
      else if (r < 9) op = 8'h52;
      else begin
        b = 8'($urandom);
        op = (b == 8'h57 || b == 8'h52) ? 8'h00 : b;
      end
      a    = ($urandom_range(0, 3) == 0) ? $urandom : (32'h0000_1000 + 32'($urandom_range(0, 63)));
      cnt  = $urandom_range(0, 4);
      flip = ($urandom_range(0, 4) == 0);
      wq.delete();
      for (int j = 0; j < cnt; j++) wq.push_back($urandom);
      if (op == 8'h57)      run_cmd(op, a, cnt, wq, flip, flip ? 'h23 : 'h59);
      else if (op == 8'h52) run_cmd(op, a, cnt, wq, 1'b0, -1);
      else                  run_cmd(op, a, cnt, wq, 1'b0, 'h3F);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
